// File: rtl/hypot_seq.sv
// hypot_seq -- multi-cycle magnitude unit: result = sqrt(a^2 + b^2).
//
// Squares both operands in parallel with an iterative shift-add multiplier
// (one multiplier bit per cycle, LSB first). It adds the squares in a single
// cycle. It then extracts the root with a bit-serial restoring square root
// (one root bit per cycle, MSB first). The latency is fixed at 2*WIDTH+2
// edges from accept to out_valid, whatever the operand values are.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a, b, round_mode are valid
//   in_ready   out  unit is idle and can accept an operation
//   a, b       in   WIDTH-bit unsigned operands
//   round_mode in   0 = floor, 1 = round to nearest
//   out_valid  out  result/exact are valid
//   out_ready  in   consumer takes the result
//   result     out  WIDTH+1-bit magnitude
//   exact      out  a^2 + b^2 is a perfect square
module hypot_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             round_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   result,
  output logic             exact
);

  localparam int CW = $clog2(WIDTH + 2);
  localparam int PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SQUARE = 3'd1,
    SUM    = 3'd2,
    SQRT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]    r_cnt;
  logic             r_round;
  logic [PW-1:0]    r_mcand_a;
  logic [PW-1:0]    r_mcand_b;
  logic [WIDTH-1:0] r_mplier_a;
  logic [WIDTH-1:0] r_mplier_b;
  logic [PW-1:0]    r_sq_a;
  logic [PW-1:0]    r_sq_b;
  logic [PW+1:0]    r_sum;   // S padded to an even bit count for 2-bit pairs
  logic [WIDTH:0]   r_root;
  logic [WIDTH+1:0] r_rem;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [WIDTH:0]   r_result;
  logic             r_exact;

  logic             w_accept;
  logic             w_handshake;
  logic             w_square_last;
  logic             w_sqrt_last;
  logic [PW:0]      w_sum;
  logic [WIDTH+3:0] w_lhs;
  logic [WIDTH+3:0] w_rhs;
  logic             w_ge;
  logic [WIDTH+1:0] w_diff;
  logic [WIDTH+1:0] w_rem_next;
  logic [WIDTH:0]   w_root_next;
  logic             w_round_up;
  logic [WIDTH:0]   w_result_next;

  assign w_accept      = in_valid && (r_state == IDLE);
  assign w_handshake   = r_out_valid && out_ready && (r_state == DONE);
  assign w_square_last = (r_cnt == CW'(WIDTH - 1));
  assign w_sqrt_last   = (r_cnt == CW'(WIDTH));
  assign w_sum         = {1'b0, r_sq_a} + {1'b0, r_sq_b};

  // Restoring square-root step: bring down the next two bits of S and try
  // subtracting (4*root + 1). The subtraction only needs the low WIDTH+2 bits
  // because a successful difference always fits in the remainder.
  always_comb begin
    w_lhs      = {r_rem, r_sum[PW+1:PW]};
    w_rhs      = {1'b0, r_root, 2'b01};
    w_ge       = (w_lhs >= w_rhs);
    w_diff     = w_lhs[WIDTH+1:0] - w_rhs[WIDTH+1:0];
    w_rem_next = w_ge ? w_diff : w_lhs[WIDTH+1:0];
    w_root_next = {r_root[WIDTH-1:0], w_ge};
    // rem > R is the same as a fractional root part above one half.
    w_round_up    = r_round && (w_rem_next > {1'b0, w_root_next});
    w_result_next = w_root_next + {{WIDTH{1'b0}}, w_round_up};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic for the fixed-length operation sequence.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (in_valid) w_state_next = SQUARE;
        else          w_state_next = IDLE;
      end
      SQUARE: begin
        if (w_square_last) w_state_next = SUM;
        else               w_state_next = SQUARE;
      end
      SUM: begin
        w_state_next = SQRT;
      end
      SQRT: begin
        if (w_sqrt_last) w_state_next = DONE;
        else             w_state_next = SQRT;
      end
      DONE: begin
        if (out_ready) w_state_next = IDLE;
        else           w_state_next = DONE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, shift-add squaring, summation, root extraction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= {CW{1'b0}};
      r_round    <= 1'b0;
      r_mcand_a  <= {PW{1'b0}};
      r_mcand_b  <= {PW{1'b0}};
      r_mplier_a <= {WIDTH{1'b0}};
      r_mplier_b <= {WIDTH{1'b0}};
      r_sq_a     <= {PW{1'b0}};
      r_sq_b     <= {PW{1'b0}};
      r_sum      <= {(PW+2){1'b0}};
      r_root     <= {(WIDTH+1){1'b0}};
      r_rem      <= {(WIDTH+2){1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt      <= {CW{1'b0}};
            r_round    <= round_mode;
            r_mcand_a  <= {{WIDTH{1'b0}}, a};
            r_mcand_b  <= {{WIDTH{1'b0}}, b};
            r_mplier_a <= a;
            r_mplier_b <= b;
            r_sq_a     <= {PW{1'b0}};
            r_sq_b     <= {PW{1'b0}};
          end
        end
        SQUARE: begin
          r_sq_a     <= r_sq_a + (r_mplier_a[0] ? r_mcand_a : {PW{1'b0}});
          r_sq_b     <= r_sq_b + (r_mplier_b[0] ? r_mcand_b : {PW{1'b0}});
          r_mcand_a  <= {r_mcand_a[PW-2:0], 1'b0};
          r_mcand_b  <= {r_mcand_b[PW-2:0], 1'b0};
          r_mplier_a <= {1'b0, r_mplier_a[WIDTH-1:1]};
          r_mplier_b <= {1'b0, r_mplier_b[WIDTH-1:1]};
          r_cnt      <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
        SUM: begin
          r_sum  <= {1'b0, w_sum};
          r_cnt  <= {CW{1'b0}};
          r_root <= {(WIDTH+1){1'b0}};
          r_rem  <= {(WIDTH+2){1'b0}};
        end
        SQRT: begin
          r_root <= w_root_next;
          r_rem  <= w_rem_next;
          r_sum  <= {r_sum[PW-1:0], 2'b00};
          r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
        end
        DONE: begin
          r_cnt <= r_cnt;
        end
        default: begin
          r_cnt <= {CW{1'b0}};
        end
      endcase
    end
  end

  // Output registers: written on the last root step, held through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= {(WIDTH+1){1'b0}};
      r_exact     <= 1'b0;
    end else begin
      r_in_ready <= (w_state_next == IDLE);
      if ((r_state == SQRT) && w_sqrt_last) begin
        r_out_valid <= 1'b1;
        r_result    <= w_result_next;
        r_exact     <= (w_rem_next == {(WIDTH+2){1'b0}});
      end else if (w_handshake) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign exact     = r_exact;

endmodule

// File: tb/tb_hypot_seq.sv
// Self-checking bench for hypot_seq (WIDTH = 8): directed corner cases,
// backpressure, asynchronous reset mid-operation and randomized operations
// checked against an arithmetic reference model.
module tb_hypot_seq;

  localparam int WIDTH = 8;
  localparam int LAT   = 2 * WIDTH + 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             round_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   result;
  logic             exact;

  int n_tests;
  int n_fail;

  hypot_seq #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .exact      (exact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Reference: integer root found by searching squares, no bit tricks.
  function automatic void ref_model(input int unsigned av, input int unsigned bv, input bit rm,
                                    output int unsigned res, output bit ex);
    longint unsigned s;
    longint unsigned r;
    longint unsigned rem;
    s = longint'(av) * av + longint'(bv) * bv;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    rem = s - r * r;
    res = (rm && rem > r) ? int'(r + 1) : int'(r);
    ex  = (rem == 0);
  endfunction

  // Runs one operation; hold = cycles of out_ready=0 after out_valid rises.
  task automatic run_op(input int unsigned av, input int unsigned bv, input bit rm,
                        input int unsigned exp_res, input bit exp_ex, input int hold,
                        input string tag);
    int edges;
    logic [WIDTH:0] held_res;
    logic held_ex;
    edges = 0;
    @(negedge clk);
    while (!in_ready && edges < 50) begin
      @(negedge clk);
      edges++;
    end
    check_val({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    a = WIDTH'(av);
    b = WIDTH'(bv);
    round_mode = rm;
    in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    round_mode = 1'($urandom);
    check_val({tag, "_busy"}, 32'(in_ready), 32'd0);
    edges = 0;
    while (!out_valid && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check_val({tag, "_latency"}, 32'(edges), 32'(LAT));
    check_val({tag, "_result"}, 32'(result), 32'(exp_res));
    check_val({tag, "_exact"}, 32'(exact), 32'(exp_ex));
    held_res = result;
    held_ex  = exact;
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 2);
      @(posedge clk);
      #1;
      check_val({tag, "_bp_valid"}, 32'(out_valid), 32'd1);
      check_val({tag, "_bp_result"}, 32'(result), 32'(held_res));
      check_val({tag, "_bp_exact"}, 32'(exact), 32'(held_ex));
      check_val({tag, "_bp_in_ready"}, 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_val({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
    check_val({tag, "_hs_in_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'(($urandom % 2));
  endtask

  typedef struct {
    int unsigned av;
    int unsigned bv;
    bit          rm;
    int unsigned res;
    bit          ex;
  } vec_t;

  vec_t dir_vecs[$];

  initial begin
    int unsigned ra;
    int unsigned rb;
    bit          rrm;
    int unsigned eres;
    bit          eex;
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    round_mode = 1'b0;
    out_ready  = 1'b0;

    #12;
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_result", 32'(result), 32'd0);
    check_val("rst_exact", 32'(exact), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    dir_vecs.push_back('{3, 4, 1'b0, 5, 1'b1});
    dir_vecs.push_back('{255, 255, 1'b0, 360, 1'b0});
    dir_vecs.push_back('{255, 255, 1'b1, 361, 1'b0});
    dir_vecs.push_back('{2, 3, 1'b0, 3, 1'b0});
    dir_vecs.push_back('{2, 3, 1'b1, 4, 1'b0});
    dir_vecs.push_back('{1, 1, 1'b1, 1, 1'b0});
    dir_vecs.push_back('{0, 0, 1'b0, 0, 1'b1});
    dir_vecs.push_back('{0, 200, 1'b0, 200, 1'b1});
    foreach (dir_vecs[i]) begin
      run_op(dir_vecs[i].av, dir_vecs[i].bv, dir_vecs[i].rm,
             dir_vecs[i].res, dir_vecs[i].ex, 0, $sformatf("dir%0d", i));
    end

    // Backpressure with an ignored in_valid pulse during DONE.
    run_op(5, 12, 1'b0, 13, 1'b1, 5, "bp");
    @(posedge clk);
    #1;
    check_val("bp_idle_after", 32'(in_ready), 32'd1);
    check_val("bp_no_extra_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of the root extraction.
    @(negedge clk);
    a = 8'd100;
    b = 8'd77;
    round_mode = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_out_valid", 32'(out_valid), 32'd0);
    check_val("arst_in_ready", 32'(in_ready), 32'd1);
    check_val("arst_result", 32'(result), 32'd0);
    check_val("arst_exact", 32'(exact), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("arst_hold_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(6, 8, 1'b0, 10, 1'b1, 0, "post_rst");

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra  = $urandom_range(0, 255);
      rb  = $urandom_range(0, 255);
      rrm = 1'($urandom % 2);
      ref_model(ra, rb, rrm, eres, eex);
      run_op(ra, rb, rrm, eres, eex, int'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
